// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: issues data-memory accesses for the EX instruction, aligns loads,
// replicates store data, and produces the writeback and forwarding view of the instruction.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_rf_en,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,

    output logic [4:0]  rd_mem,
    output logic        rf_en_mem,
    output logic [31:0] wb_data,

    output logic        stall,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned CNTW = 8;
    localparam logic [CNTW-1:0] TIMEOUT_LAST = CNTW'(TIMEOUT_CYCLES - 1);

    // Stage occupancy, decoded each cycle from the stage register
    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_ALU      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_MISALIGN = 2'd3
    } stage_state_t;

    logic            valid_q;
    logic [REGW-1:0] rd_q;
    logic            rf_en_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] sdata_q;
    logic            load_q;
    logic            store_q;
    logic [2:0]      f3_q;
    logic [CNTW-1:0] wait_cnt;

    stage_state_t    state;
    logic            is_byte;
    logic            is_half;
    logic            is_unsigned;
    logic            misaligned;
    logic            timeout_hit;
    logic [3:0]      store_mask;
    logic [7:0]      byte_lane;
    logic [15:0]     half_lane;
    logic [XLEN-1:0] load_data;

    // Stage register: captures EX whenever the stage is not frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            rf_en_q <= 1'b0;
            alu_q   <= '0;
            sdata_q <= '0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            f3_q    <= '0;
        end else if (!stall) begin
            valid_q <= ex_valid;
            rd_q    <= ex_rd;
            rf_en_q <= ex_rf_en;
            alu_q   <= ex_alu_result;
            sdata_q <= ex_store_data;
            load_q  <= ex_is_load;
            store_q <= ex_is_store;
            f3_q    <= ex_funct3;
        end
    end

    // Wait counter: counts un-acked request cycles, restarts whenever the stage moves on
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (stall) begin
            wait_cnt <= wait_cnt + CNTW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign is_byte     = (f3_q[1:0] == 2'b00);
    assign is_half     = (f3_q[1:0] == 2'b01);
    assign is_unsigned = f3_q[2];
    assign misaligned  = is_half ? alu_q[0] : (!is_byte && (alu_q[1:0] != 2'b00));

    always_comb begin
        state = ST_EMPTY;
        if (valid_q) begin
            if (!(load_q || store_q)) begin
                state = ST_ALU;
            end else if (misaligned) begin
                state = ST_MISALIGN;
            end else begin
                state = ST_MEM_WAIT;
            end
        end
    end

    always_comb begin
        store_mask = 4'b1111;
        if (is_byte) begin
            store_mask = 4'b0001 << alu_q[1:0];
        end else if (is_half) begin
            store_mask = 4'b0011 << alu_q[1:0];
        end
    end

    always_comb begin
        dmem_wdata = sdata_q;
        case (f3_q[1:0])
            2'b00:   dmem_wdata = {4{sdata_q[7:0]}};
            2'b01:   dmem_wdata = {2{sdata_q[15:0]}};
            default: dmem_wdata = sdata_q;
        endcase
    end

    // Request, stall and error outputs; an ack in the timeout cycle counts as completion
    always_comb begin
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_wstrb   = 4'b0000;
        misalign_err = 1'b0;
        timeout_hit  = 1'b0;
        stall        = 1'b0;
        bus_err      = 1'b0;
        case (state)
            ST_MEM_WAIT: begin
                dmem_req    = 1'b1;
                dmem_we     = store_q;
                dmem_wstrb  = store_q ? store_mask : 4'b0000;
                timeout_hit = !dmem_ack && (wait_cnt == TIMEOUT_LAST);
                stall       = !dmem_ack && !timeout_hit;
                bus_err     = timeout_hit;
            end
            ST_MISALIGN: begin
                misalign_err = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dmem_addr = alu_q;
    assign byte_lane = dmem_rdata[{alu_q[1:0], 3'b000} +: 8];
    assign half_lane = alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        load_data = dmem_rdata;
        if (is_byte) begin
            load_data = {{24{!is_unsigned && byte_lane[7]}}, byte_lane};
        end else if (is_half) begin
            load_data = {{16{!is_unsigned && half_lane[15]}}, half_lane};
        end
    end

    always_comb begin
        wb_data = '0;
        if (valid_q) begin
            wb_data = load_q ? load_data : alu_q;
        end
    end

    assign rd_mem    = rd_q;
    assign rf_en_mem = valid_q && rf_en_q && (rd_q != '0) && (state != ST_MISALIGN)
                       && (!load_q || dmem_ack) && !timeout_hit;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed instruction sequence, a per-cycle reference model of the
// stage outputs, and literal expectations on the key scenarios.
module tb_mem_wb_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_rf_en;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [4:0]  rd_mem;
    logic        rf_en_mem;
    logic [31:0] wb_data;
    logic        stall;
    logic        misalign_err;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_rf_en(ex_rf_en),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .rd_mem(rd_mem), .rf_en_mem(rf_en_mem), .wb_data(wb_data),
        .stall(stall), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        rf_en;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
    } instr_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [4:0]  rd;
        logic        rf_en;
        logic [31:0] wb;
        logic        stall;
        logic        mis;
        logic        berr;
    } exp_t;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Outputs implied by the instruction held in the stage and how long it has waited
    function automatic exp_t predict(input instr_t s, input int waited, input logic ack,
                                     input logic [31:0] rdata);
        exp_t        e;
        int          size;
        int          off;
        logic        mis;
        logic        tout;
        logic [31:0] v;
        size = (s.f3[1:0] == 2'b00) ? 1 : (s.f3[1:0] == 2'b01) ? 2 : 4;
        off  = int'(s.alu % 4);
        mis  = s.valid && (s.ld || s.st) && ((off % size) != 0);
        e.req   = s.valid && (s.ld || s.st) && !mis;
        tout    = e.req && !ack && (waited == int'(TO) - 1);
        e.stall = e.req && !ack && !tout;
        e.we    = e.req && s.st;
        e.addr  = s.alu;
        if (size == 1)      e.wdata = (s.sdata & 32'hFF) * 32'h0101_0101;
        else if (size == 2) e.wdata = (s.sdata & 32'hFFFF) * 32'h0001_0001;
        else                e.wdata = s.sdata;
        e.wstrb = (e.req && s.st) ? 4'((((1 << size) - 1) << off) & 15) : 4'b0000;
        if (size == 1) begin
            v = (rdata >> (8 * off)) & 32'hFF;
            if (!s.f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2) begin
            v = (rdata >> (s.alu[1] ? 16 : 0)) & 32'hFFFF;
            if (!s.f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        e.wb    = !s.valid ? 32'h0 : (s.ld ? v : s.alu);
        e.rd    = s.rd;
        e.rf_en = s.valid && s.rf_en && (s.rd != 5'd0) && !mis && (!s.ld || ack) && !tout;
        e.mis   = mis;
        e.berr  = tout;
        return e;
    endfunction

    instr_t m;
    int     waited = 0;
    logic   model_ok = 1'b0;

    // Reference compare on every falling edge, then advance the model to the next rising edge
    always @(negedge clk) begin
        exp_t e;
        e = '0;
        if (model_ok) begin
            e = predict(m, waited, dmem_ack, dmem_rdata);
            cmp("m_req",   32'(dmem_req),     32'(e.req));
            cmp("m_we",    32'(dmem_we),      32'(e.we));
            cmp("m_addr",  dmem_addr,         e.addr);
            cmp("m_wdata", dmem_wdata,        e.wdata);
            cmp("m_wstrb", 32'(dmem_wstrb),   32'(e.wstrb));
            cmp("m_rd",    32'(rd_mem),       32'(e.rd));
            cmp("m_rfen",  32'(rf_en_mem),    32'(e.rf_en));
            cmp("m_wb",    wb_data,           e.wb);
            cmp("m_stall", 32'(stall),        32'(e.stall));
            cmp("m_mis",   32'(misalign_err), 32'(e.mis));
            cmp("m_berr",  32'(bus_err),      32'(e.berr));
        end
        if (rst) begin
            m        = '0;
            waited   = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (!e.stall) begin
                m.valid = ex_valid;
                m.rd    = ex_rd;
                m.rf_en = ex_rf_en;
                m.alu   = ex_alu_result;
                m.sdata = ex_store_data;
                m.ld    = ex_is_load;
                m.st    = ex_is_store;
                m.f3    = ex_funct3;
                waited  = 0;
            end else begin
                waited++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic rf, input logic [31:0] alu,
                         input logic [31:0] sd, input logic ld, input logic st, input logic [2:0] f3);
        ex_valid      = 1'b1;
        ex_rd         = rd;
        ex_rf_en      = rf;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_is_load    = ld;
        ex_is_store   = st;
        ex_funct3     = f3;
    endtask

    task automatic idle();
        ex_valid    = 1'b0;
        ex_rf_en    = 1'b0;
        ex_is_load  = 1'b0;
        ex_is_store = 1'b0;
    endtask

    // Single-cycle load with an immediate ack; checks the written-back value
    task automatic quick_load(input string name, input logic [4:0] rd, input logic [31:0] addr,
                              input logic [2:0] f3, input logic [31:0] rdata,
                              input logic [31:0] exp_wb, input logic exp_rf);
        issue(rd, 1'b1, addr, 32'h0, 1'b1, 1'b0, f3);
        dmem_rdata = rdata;
        tick();
        idle();
        dmem_ack = 1'b1;
        @(negedge clk);
        cmp({name, "_wb"},    wb_data,          exp_wb);
        cmp({name, "_rfen"},  32'(rf_en_mem),   32'(exp_rf));
        cmp({name, "_stall"}, 32'(stall),       32'h0);
        tick();
        dmem_ack = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        ex_rd         = 5'd0;
        ex_alu_result = 32'h0;
        ex_store_data = 32'h0;
        ex_funct3     = 3'b000;
        idle();
        dmem_ack      = 1'b0;
        dmem_rdata    = 32'h0;
        tick();
        tick();
        @(negedge clk);
        cmp("rst_req",   32'(dmem_req),   32'h0);
        cmp("rst_wstrb", 32'(dmem_wstrb), 32'h0);
        cmp("rst_wb",    wb_data,         32'h0);
        cmp("rst_rd",    32'(rd_mem),     32'h0);
        cmp("rst_addr",  dmem_addr,       32'h0);
        cmp("rst_stall", 32'(stall),      32'h0);
        tick();
        rst = 1'b0;

        // ALU op writes back one cycle after capture
        issue(5'd5, 1'b1, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 3'b000);
        tick();
        idle();
        @(negedge clk);
        cmp("alu_rd",    32'(rd_mem),    32'd5);
        cmp("alu_rfen",  32'(rf_en_mem), 32'h1);
        cmp("alu_wb",    wb_data,        32'h1234_5678);
        cmp("alu_stall", 32'(stall),     32'h0);
        tick();

        // lb / lbu from lane 3, ack arriving in the same cycle the timeout count is reached
        dmem_rdata = 32'h80FF_FFFF;
        for (int k = 0; k < 2; k++) begin
            issue(5'd7, 1'b1, 32'h0000_0103, 32'h0, 1'b1, 1'b0, (k == 0) ? 3'b000 : 3'b100);
            tick();
            idle();
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                cmp("lb_stall", 32'(stall),    32'h1);
                cmp("lb_req",   32'(dmem_req), 32'h1);
                tick();
            end
            dmem_ack = 1'b1;
            @(negedge clk);
            cmp("lb_wb",    wb_data, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            cmp("lb_rfen",  32'(rf_en_mem), 32'h1);
            cmp("lb_stall", 32'(stall),     32'h0);
            cmp("lb_berr",  32'(bus_err),   32'h0);
            tick();
            dmem_ack = 1'b0;
        end

        // sh to upper halfword
        issue(5'd0, 1'b0, 32'h0000_0202, 32'hAAAA_BEEF, 1'b0, 1'b1, 3'b001);
        tick();
        idle();
        dmem_ack = 1'b1;
        @(negedge clk);
        cmp("sh_we",    32'(dmem_we),    32'h1);
        cmp("sh_wdata", dmem_wdata,      32'hBEEF_BEEF);
        cmp("sh_wstrb", 32'(dmem_wstrb), 32'hC);
        cmp("sh_rfen",  32'(rf_en_mem),  32'h0);
        tick();

        // sb to lane 1
        issue(5'd0, 1'b0, 32'h0000_0301, 32'h1234_5678, 1'b0, 1'b1, 3'b000);
        tick();
        idle();
        @(negedge clk);
        cmp("sb_wdata", dmem_wdata,      32'h7878_7878);
        cmp("sb_wstrb", 32'(dmem_wstrb), 32'h2);
        tick();
        dmem_ack = 1'b0;

        // Misaligned lw
        issue(5'd6, 1'b1, 32'h0000_0101, 32'h0, 1'b1, 1'b0, 3'b010);
        tick();
        idle();
        @(negedge clk);
        cmp("mis_err",   32'(misalign_err), 32'h1);
        cmp("mis_req",   32'(dmem_req),     32'h0);
        cmp("mis_rfen",  32'(rf_en_mem),    32'h0);
        cmp("mis_stall", 32'(stall),        32'h0);
        tick();
        @(negedge clk);
        cmp("mis_pulse", 32'(misalign_err), 32'h0);

        // Load that is never acked
        issue(5'd3, 1'b1, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 3'b010);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp("to_stall", 32'(stall),   32'h1);
            cmp("to_berr",  32'(bus_err), 32'h0);
            tick();
        end
        @(negedge clk);
        cmp("to_berr_hit", 32'(bus_err),   32'h1);
        cmp("to_stall_0",  32'(stall),     32'h0);
        cmp("to_rfen",     32'(rf_en_mem), 32'h0);
        tick();
        @(negedge clk);
        cmp("to_req_drop", 32'(dmem_req), 32'h0);
        cmp("to_berr_end", 32'(bus_err),  32'h0);

        // Halfword loads and a load to x0
        quick_load("lh_hi",  5'd10, 32'h0000_0102, 3'b001, 32'h8001_7FFF, 32'hFFFF_8001, 1'b1);
        quick_load("lhu_hi", 5'd11, 32'h0000_0102, 3'b101, 32'h8001_7FFF, 32'h0000_8001, 1'b1);
        quick_load("lh_lo",  5'd12, 32'h0000_0100, 3'b001, 32'h8001_7FFF, 32'h0000_7FFF, 1'b1);
        quick_load("lw_x0",  5'd0,  32'h0000_0104, 3'b010, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);

        // Younger ALU op held in EX while a load waits
        dmem_rdata = 32'h0BAD_CAFE;
        issue(5'd8, 1'b1, 32'h0000_0108, 32'h0, 1'b1, 1'b0, 3'b010);
        tick();
        issue(5'd9, 1'b1, 32'h0000_0055, 32'h0, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        cmp("hold_stall", 32'(stall),  32'h1);
        cmp("hold_rd",    32'(rd_mem), 32'd8);
        tick();
        dmem_ack = 1'b1;
        @(negedge clk);
        cmp("hold_ld_wb",   wb_data,        32'h0BAD_CAFE);
        cmp("hold_ld_rfen", 32'(rf_en_mem), 32'h1);
        tick();
        dmem_ack = 1'b0;
        idle();
        @(negedge clk);
        cmp("hold_alu_rd", 32'(rd_mem), 32'd9);
        cmp("hold_alu_wb", wb_data,     32'h0000_0055);
        tick();

        // Ack with no request outstanding
        dmem_ack = 1'b1;
        @(negedge clk);
        cmp("noreq_stall", 32'(stall),    32'h0);
        cmp("noreq_req",   32'(dmem_req), 32'h0);
        tick();
        dmem_ack = 1'b0;

        // Reset while waiting on memory
        issue(5'd4, 1'b1, 32'h0000_010C, 32'h0, 1'b1, 1'b0, 3'b010);
        tick();
        idle();
        @(negedge clk);
        cmp("rmw_stall", 32'(stall), 32'h1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        cmp("rmw_req",   32'(dmem_req),  32'h0);
        cmp("rmw_rfen",  32'(rf_en_mem), 32'h0);
        cmp("rmw_wb",    wb_data,        32'h0);
        cmp("rmw_berr",  32'(bus_err),   32'h0);
        cmp("rmw_stall", 32'(stall),     32'h0);
        cmp("rmw_addr",  dmem_addr,      32'h0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max dmem_ack wait cycles before abort (1..255).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have inputs ex_valid 1, ex_rd 5, ex_rf_en 1, ex_alu_result 32, ex_store_data 32: the EX-stage instruction.
REQ-005 SHALL have inputs ex_is_load 1, ex_is_store 1, ex_funct3 3: access type and size (RV32I load/store funct3).
REQ-006 SHALL have outputs dmem_req 1, dmem_we 1, dmem_addr 32, dmem_wdata 32, dmem_wstrb 4: data-memory request.
REQ-007 SHALL have inputs dmem_ack 1, dmem_rdata 32: data-memory completion and word-aligned read data.
REQ-008 SHALL have outputs rd_mem 5, rf_en_mem 1, wb_data 32: writeback and forwarding source for the forwarding unit.
REQ-009 SHALL have outputs stall 1 (freeze upstream), misalign_err 1, bus_err 1 (one-cycle error pulses).

Function
REQ-010 Stage register (valid_q, rd_q, rf_en_q, alu_q, sdata_q, load_q, store_q, f3_q) SHALL load EX inputs on each edge where stall=0 and hold where stall=1.
REQ-011 States, derived from stage register: EMPTY (valid_q=0), ALU (valid_q=1, no mem op), MEM_WAIT (valid_q=1, load_q or store_q, aligned, not yet acked/aborted).
REQ-012 Misaligned: lh/lhu/sh with alu_q[0]=1, lw/sw with alu_q[1:0]!=0; such ops SHALL raise misalign_err, assert no dmem_req, no rf write, stall=0.
REQ-013 dmem_req SHALL be 1 exactly in MEM_WAIT, held until dmem_ack or abort; dmem_addr=alu_q, dmem_we=store_q.
REQ-014 Store data: sb replicates sdata_q[7:0] x4, wstrb=0001<<alu_q[1:0]; sh replicates [15:0] x2, wstrb=0011<<alu_q[1:0]; sw wdata=sdata_q, wstrb=1111; wstrb=0000 for loads.
REQ-015 Load extract from dmem_rdata by alu_q[1:0]: lb/lbu byte lane sign/zero-extended; lh/lhu halfword at alu_q[1] sign/zero-extended; lw full word.
REQ-016 stall SHALL equal dmem_req & ~dmem_ack & ~timeout_hit (combinational); ALU and EMPTY states never stall.
REQ-017 Wait counter (8 bit) SHALL increment each cycle dmem_req=1 & dmem_ack=0, clear on ack, abort or stage advance; timeout_hit = (count == TIMEOUT_CYCLES-1) & dmem_req & ~dmem_ack.
REQ-018 On timeout_hit: bus_err=1 for that cycle, instruction retires without rf write, stage advances next edge.
REQ-019 rf_en_mem = valid_q & rf_en_q & (rd_q!=0) & ~misaligned & (~load_q | dmem_ack) & ~timeout_hit.
REQ-020 rd_mem = rd_q always; wb_data = extracted load data when load_q, else alu_q; 0 in EMPTY.
REQ-021 Latency: ALU op writes back 1 cycle after EX capture; load writes back in the dmem_ack cycle; ack in first MEM_WAIT cycle gives zero stall.
REQ-022 dmem_ack SHALL be ignored when dmem_req=0.
REQ-023 Simultaneous ack and timeout count: ack wins (normal completion, no bus_err).

Reset
REQ-024 On rst=1 at a clock edge, all stage registers and wait counter SHALL clear; valid_q=0.
REQ-025 Following that edge: dmem_req, dmem_we, rf_en_mem, stall, misalign_err, bus_err = 0; dmem_wstrb=0000; rd_mem=0; wb_data=0; dmem_addr=0.
REQ-026 Reset mid-MEM_WAIT SHALL abandon the access: dmem_req=0 next cycle, no writeback, no error pulse.

Verification
REQ-027 ALU: ex_rd=5, rf_en=1, alu=0x1234_5678 -> next cycle rd_mem=5, rf_en_mem=1, wb_data=0x1234_5678, stall=0.
REQ-028 lb addr 0x103, rdata=0x80FF_FFFF, ack after 3 cycles -> stall=1 for 3 cycles, ack cycle wb_data=0xFFFF_FF80, rf_en_mem=1; lbu same -> 0x0000_0080.
REQ-029 sh addr 0x202, sdata=0xAAAA_BEEF -> dmem_we=1, wdata=0xBEEF_BEEF, wstrb=1100, rf_en_mem=0.
REQ-030 lw addr 0x101 -> misalign_err one cycle, dmem_req=0, rf_en_mem=0, stall=0.
REQ-031 Load with ack never arriving, TIMEOUT_CYCLES=4 -> stall=1 for 3 cycles, 4th cycle bus_err=1, stall=0, rf_en_mem=0.
REQ-032 Load to rd=0 with ack -> rf_en_mem=0; rst asserted during MEM_WAIT -> dmem_req=0 next cycle, all outputs at reset values.
